matrix_scan_driver: RTL and testbench



---
 rtl/matrix_scan_driver_pkg.sv | 19 +
 rtl/matrix_scan_driver_if.sv | 29 ++
 rtl/matrix_scan_driver_tick_gen.sv | 26 ++
 rtl/matrix_scan_driver.sv | 189 ++++++++++++++++++
 tb/tb_matrix_scan_driver.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_scan_driver_pkg.sv
// Shared defaults and types for the matrix scan driver slice.
package matrix_pkg;

   localparam int DEF_ROWS    = 16;
   localparam int DEF_COLS    = 16;
   localparam int DEF_DEPTH   = 2;
   localparam int DEF_CLK_DIV = 4;

   typedef logic [DEF_DEPTH-1:0] pixel_t;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      LATCH,
      NEXT
   } scan_state_t;

endpackage

// File: rtl/matrix_scan_driver_if.sv
// Pixel-write / swap side and matrix-board side of the scan driver.
interface matrix_scan_driver_if
   import matrix_pkg::*;
#(
   parameter int ROWS  = DEF_ROWS,
   parameter int COLS  = DEF_COLS,
   parameter int DEPTH = DEF_DEPTH
);
   logic                     wr_en;
   logic [$clog2(ROWS)-1:0]  wr_row;
   logic [$clog2(COLS)-1:0]  wr_col;
   logic [DEPTH-1:0]         wr_data;
   logic                     swap_req;
   logic                     swap_pending;
   logic                     sclk;
   logic                     sdata;
   logic                     latch;
   logic                     frame_done;

   modport master (
      output wr_en, wr_row, wr_col, wr_data, swap_req,
      input  swap_pending, sclk, sdata, latch, frame_done
   );

   modport slave (
      input  wr_en, wr_row, wr_col, wr_data, swap_req,
      output swap_pending, sclk, sdata, latch, frame_done
   );
endinterface

// File: rtl/matrix_scan_driver_tick_gen.sv
// Free-running 0..CLK_DIV-1 divider with a one-cycle tick on wrap.
module tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_tick
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] r_div;

   // Clearing realigns the divider so a new word starts on a full tick.
   assign o_tick = !i_clr && (r_div == DW'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= '0;
      end else if (i_clr || o_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DW'(1);
      end
   end
endmodule

// File: rtl/matrix_scan_driver.sv
// Double-buffered grayscale frame buffer scanned out as row one-hot + column bits.
// state    | meaning
// IDLE     | after reset, wait for first tick
// SHIFT_LO | present current bit, sclk low
// SHIFT_HI | sclk high, bit sampled by the board
// LATCH    | one tick of latch strobe
// NEXT     | one clk: advance subframe/row, handle frame boundary
module matrix_scan_driver
   import matrix_pkg::*;
#(
   parameter int ROWS    = DEF_ROWS,
   parameter int COLS    = DEF_COLS,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input logic                 clk,
   input logic                 rst,
   matrix_scan_driver_if.slave bus
);
   localparam int W  = ROWS + COLS;
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int BW = $clog2(W);
   localparam logic [DEPTH-1:0] S_MAX = DEPTH'((1 << DEPTH) - 1);

   scan_state_t      r_state;
   scan_state_t      w_state_n;
   logic [DEPTH-1:0] r_bank [2][ROWS][COLS];
   logic             r_front;
   logic             w_front_n;
   logic [RW-1:0]    r_row;
   logic [RW-1:0]    w_row_n;
   logic [DEPTH-1:0] r_s;
   logic [DEPTH-1:0] w_s_n;
   logic [BW-1:0]    r_bit;
   logic [W-1:0]     r_word;
   logic [W-1:0]     w_word_n;
   logic [COLS-1:0]  w_col_n;
   logic [ROWS-1:0]  w_row_oh;
   logic             r_swap_pending;
   logic             w_tick;
   logic             w_tick_clr;
   logic             w_load;
   logic             w_shift;
   logic             w_last_bit;
   logic             w_boundary;
   logic             w_wr_ok;
   logic             w_sclk;
   logic             w_sdata;
   logic             w_latch;

   tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_tick_clr),
      .o_tick (w_tick)
   );

   assign w_last_bit = (r_bit == BW'(W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         IDLE:     if (w_tick) w_state_n = SHIFT_LO;
         SHIFT_LO: if (w_tick) w_state_n = SHIFT_HI;
         SHIFT_HI: if (w_tick) w_state_n = w_last_bit ? LATCH : SHIFT_LO;
         LATCH:    if (w_tick) w_state_n = NEXT;
         NEXT:     w_state_n = SHIFT_LO;
         default:  w_state_n = IDLE;
      endcase
   end

   always_comb begin
      w_sclk     = 1'b0;
      w_sdata    = 1'b0;
      w_latch    = 1'b0;
      w_load     = 1'b0;
      w_shift    = 1'b0;
      w_tick_clr = 1'b0;
      case (r_state)
         IDLE:     w_load = w_tick;
         SHIFT_LO: w_sdata = r_word[W-1];
         SHIFT_HI: begin
            w_sclk  = 1'b1;
            w_sdata = r_word[W-1];
            w_shift = w_tick && !w_last_bit;
         end
         LATCH:    w_latch = 1'b1;
         NEXT: begin
            w_load     = 1'b1;
            w_tick_clr = 1'b1;
         end
         default: ;
      endcase
   end

   // Position of the word about to start; only moves during NEXT.
   always_comb begin
      w_row_n    = r_row;
      w_s_n      = r_s;
      w_front_n  = r_front;
      w_boundary = 1'b0;
      if (r_state == NEXT) begin
         if (r_s != S_MAX) begin
            w_s_n = r_s + DEPTH'(1);
         end else begin
            w_s_n = DEPTH'(1);
            if (r_row == RW'(ROWS - 1)) begin
               w_row_n    = '0;
               w_boundary = 1'b1;
               if (r_swap_pending || bus.swap_req) w_front_n = ~r_front;
            end else begin
               w_row_n = r_row + RW'(1);
            end
         end
      end
   end

   always_comb begin
      w_col_n = '0;
      for (int c = 0; c < COLS; c++) begin
         w_col_n[c] = (r_bank[w_front_n][w_row_n][c] >= w_s_n);
      end
   end

   assign w_row_oh = ROWS'(1) << w_row_n;
   assign w_word_n = {w_row_oh, w_col_n};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word         <= '0;
         r_bit          <= '0;
         r_row          <= '0;
         r_s            <= DEPTH'(1);
         r_front        <= 1'b0;
         r_swap_pending <= 1'b0;
      end else begin
         if (w_load) begin
            r_word <= w_word_n;
            r_bit  <= '0;
         end else if (w_shift) begin
            r_word <= {r_word[W-2:0], 1'b0};
            r_bit  <= r_bit + BW'(1);
         end
         r_row   <= w_row_n;
         r_s     <= w_s_n;
         r_front <= w_front_n;
         if (w_boundary) begin
            r_swap_pending <= 1'b0;
         end else if (bus.swap_req) begin
            r_swap_pending <= 1'b1;
         end
      end
   end

   assign w_wr_ok = bus.wr_en
                 && ({1'b0, bus.wr_row} < (RW + 1)'(ROWS))
                 && ({1'b0, bus.wr_col} < (CW + 1)'(COLS));

   // Writes always target the bank that is not being displayed right now.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < ROWS; r++) begin
               for (int c = 0; c < COLS; c++) begin
                  r_bank[b][r][c] <= '0;
               end
            end
         end
      end else if (w_wr_ok) begin
         r_bank[~r_front][bus.wr_row][bus.wr_col] <= bus.wr_data;
      end
   end

   assign bus.sclk         = w_sclk;
   assign bus.sdata        = w_sdata;
   assign bus.latch        = w_latch;
   assign bus.frame_done   = w_boundary;
   assign bus.swap_pending = r_swap_pending & ~w_boundary;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench: 16x16 DEPTH=2 CLK_DIV=1 instance for content, 8x8 DEPTH=1 CLK_DIV=4 for timing.
module tb_matrix_scan_driver;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   matrix_scan_driver_if #(.ROWS(16), .COLS(16), .DEPTH(2)) bus_a ();
   matrix_scan_driver_if #(.ROWS(8),  .COLS(8),  .DEPTH(1)) bus_b ();

   matrix_scan_driver #(.ROWS(16), .COLS(16), .DEPTH(2), .CLK_DIV(1)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   matrix_scan_driver #(.ROWS(8), .COLS(8), .DEPTH(1), .CLK_DIV(4)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int          n_vec  = 0;
   int          n_miss = 0;
   int          cyc    = 0;
   int          mon_nbits;
   int          mon_wcnt;
   logic [31:0] mon_sh;
   logic        mon_ps;
   logic        mon_pl;
   logic [31:0] exp_q [$];
   logic [31:0] fw [48];
   bit          b_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic fill_default();
      logic [15:0] oh;
      for (int r = 0; r < 16; r++) begin
         oh = 16'h0001 << r;
         for (int s = 0; s < 3; s++) fw[r*3+s] = {oh, 16'h0000};
      end
   endtask

   task automatic push_frame();
      for (int i = 0; i < 48; i++) exp_q.push_back(fw[i]);
   endtask

   task automatic px_write(input int r, input int c, input int v);
      @(negedge clk);
      bus_a.wr_en   = 1'b1;
      bus_a.wr_row  = 4'(r);
      bus_a.wr_col  = 4'(c);
      bus_a.wr_data = 2'(v);
      @(negedge clk);
      bus_a.wr_en   = 1'b0;
   endtask

   task automatic swap_pulse();
      @(negedge clk);
      bus_a.swap_req = 1'b1;
      @(negedge clk);
      bus_a.swap_req = 1'b0;
   endtask

   task automatic wait_fd(output logic pend_prev, output logic pend_at);
      int   n;
      logic prev;
      n    = 0;
      prev = bus_a.swap_pending;
      @(negedge clk);
      while (!bus_a.frame_done && n < 4000) begin
         prev = bus_a.swap_pending;
         @(negedge clk);
         n++;
      end
      if (!bus_a.frame_done) begin
         n_vec++;
         n_miss++;
         $display("FAIL frame_done_timeout: none within %0d cycles", n);
      end
      pend_prev = prev;
      pend_at   = bus_a.swap_pending;
   endtask

   // Word monitor for instance A: assemble bits on sclk rises, check on latch.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_nbits = 0;
            mon_wcnt  = 0;
            mon_sh    = '0;
            mon_ps    = 1'b0;
            mon_pl    = 1'b0;
         end else begin
            if (bus_a.sclk && !mon_ps) begin
               mon_sh = {mon_sh[30:0], bus_a.sdata};
               mon_nbits++;
            end
            if (bus_a.latch && !mon_pl) begin
               chk("latch_bit_count", 64'(mon_nbits), 64'd32);
               if (exp_q.size() > 0) chk($sformatf("word%0d", mon_wcnt), mon_sh, exp_q.pop_front());
               mon_nbits = 0;
               mon_wcnt++;
            end
            mon_ps = bus_a.sclk;
            mon_pl = bus_a.latch;
         end
      end
   end

   // Timing monitor for instance B.
   int   b_n, b_last_rise, b_per, b_bits, b_wbits, b_fd_last, b_fd_int;
   logic b_ps, b_pl;
   initial begin
      b_n = 0; b_last_rise = -1; b_per = -1; b_bits = 0; b_wbits = -1;
      b_fd_last = -1; b_fd_int = -1; b_ps = 1'b0; b_pl = 1'b0;
      while (b_n < 6000 && b_fd_int < 0) begin
         @(negedge clk);
         b_n++;
         if (rst === 1'b0) begin
            if (bus_b.sclk && !b_ps) begin
               if (b_last_rise >= 0 && b_per < 0) b_per = b_n - b_last_rise;
               b_last_rise = b_n;
               b_bits++;
            end
            if (bus_b.latch && !b_pl) begin
               if (b_wbits < 0) b_wbits = b_bits;
               b_bits = 0;
            end
            if (bus_b.frame_done) begin
               if (b_fd_last >= 0) b_fd_int = b_n - b_fd_last;
               b_fd_last = b_n;
            end
            b_ps = bus_b.sclk;
            b_pl = bus_b.latch;
         end
      end
      chk("b_sclk_period", 64'(b_per), 64'd8);
      chk("b_word_bits", 64'(b_wbits), 64'd16);
      chk("b_frame_period", 64'(b_fd_int), 64'd1064);
      b_done = 1'b1;
   end

   logic pp, pa;
   int   t1, t2, n_wait;

   initial begin
      rst            = 1'b1;
      bus_a.wr_en    = 1'b0; bus_a.wr_row = '0; bus_a.wr_col = '0;
      bus_a.wr_data  = '0;   bus_a.swap_req = 1'b0;
      bus_b.wr_en    = 1'b0; bus_b.wr_row = '0; bus_b.wr_col = '0;
      bus_b.wr_data  = '0;   bus_b.swap_req = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_sclk",  bus_a.sclk, 1'b0);
      chk("rst_sdata", bus_a.sdata, 1'b0);
      chk("rst_latch", bus_a.latch, 1'b0);
      chk("rst_pend",  bus_a.swap_pending, 1'b0);
      chk("rst_done",  bus_a.frame_done, 1'b0);
      rst = 1'b0;

      // Frame 0: all zero; swap requested mid-frame must not disturb it.
      fill_default();
      push_frame();
      repeat (500) @(negedge clk);
      px_write(2, 5, 2);
      chk("pend_idle", bus_a.swap_pending, 1'b0);
      swap_pulse();
      chk("pend_set", bus_a.swap_pending, 1'b1);
      wait_fd(pp, pa);
      chk("pend_before_fd0", pp, 1'b1);
      chk("pend_at_fd0", pa, 1'b0);
      t1 = cyc;

      // Frame 1: bank1 with (2,5)=2.
      fill_default();
      fw[6] = 32'h0004_0020;
      fw[7] = 32'h0004_0020;
      fw[8] = 32'h0004_0000;
      push_frame();
      px_write(0, 0, 3);
      px_write(0, 15, 1);
      swap_pulse();
      wait_fd(pp, pa);
      chk("pend_at_fd1", pa, 1'b0);
      t2 = cyc;
      chk("a_frame_period", 64'(t2 - t1), 64'd3168);

      // Frame 2: bank0 with (0,0)=3 and (0,15)=1.
      fill_default();
      fw[0] = 32'h0001_8001;
      fw[1] = 32'h0001_0001;
      fw[2] = 32'h0001_0001;
      push_frame();
      wait_fd(pp, pa);

      // Frame 3 unchecked; abort row 5's word during bit 10.
      n_wait = 0;
      @(negedge clk);
      while (!((mon_wcnt % 48) == 15 && mon_nbits == 10 && bus_a.sclk == 1'b0) && n_wait < 4000) begin
         @(negedge clk);
         n_wait++;
      end
      chk("bit10_reached", 64'(n_wait < 4000), 64'd1);
      @(posedge clk);
      #1;
      chk("bit10_sclk",  bus_a.sclk, 1'b1);
      chk("bit10_sdata", bus_a.sdata, 1'b1);
      rst = 1'b1;
      #1;
      chk("abort_sclk",  bus_a.sclk, 1'b0);
      chk("abort_sdata", bus_a.sdata, 1'b0);
      chk("abort_latch", bus_a.latch, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) exp_q.push_back(32'h0001_0000);
      n_wait = 0;
      while (exp_q.size() > 0 && n_wait < 400) begin
         @(negedge clk);
         n_wait++;
      end
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

      n_wait = 0;
      while (!b_done && n_wait < 2000) begin
         @(negedge clk);
         n_wait++;
      end
      if (!b_done) begin
         n_vec++;
         n_miss++;
         $display("FAIL b_timeout: timing monitor did not complete");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
